memory: RTL and testbench
=========================

Name: memory

Overview:
- Word-organised data memory for the single-cycle MIPS datapath; it sits behind the ALU address path.
- Reads are combinational (asynchronous), so load data is available in the same cycle.
- Writes are synchronous on the rising clock edge when MemWrite is high; sw data commits at the end of the cycle.
- Contents are cleared by an asynchronous active-low reset.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, minimum 4.
- ADDR_W, 32, width of the byte address bus.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset; clears every word to 0.
- MemWrite  input  1  write enable, sampled at the rising edge of clk.
- addr  input  ADDR_W  byte address; word index = addr[log2(DEPTH)+1:2].
- write_data  input  32  data written to the addressed word.
- read_data  output  32  contents of the addressed word, combinational.

Behaviour:
- Storage is DEPTH x 32-bit words, little significance attached to byte lanes; only full-word access is supported.
- Address decode:
  - addr[1:0] is ignored; misaligned addresses access the containing word.
  - Word index = addr[log2(DEPTH)+1:2].
  - Any set bit in addr above bit log2(DEPTH)+1 marks the access out of range.
- Read:
  - read_data = mem[index], combinational and with zero latency.
  - It updates whenever addr changes or the addressed word changes.
  - An out-of-range read returns 32'h00000000.
- Write:
  - At posedge clk with rst_n=1 and MemWrite=1, mem[index] <= write_data.
  - An out-of-range write is ignored; no aliasing into the array.
  - With MemWrite=0, no word changes.
- Read-during-write, same address:
  - Before the edge, read_data shows the old value.
  - After the edge it shows write_data in the same delta, with no extra cycle.
- Reset:
  - rst_n=0 immediately, without waiting for the clock, forces every word to 0, so read_data = 0 for all addresses.
  - Writes are blocked for as long as rst_n=0.
  - Deassertion is synchronised by the system; the first write can occur at the first posedge after rst_n rises.
- Reset mid-operation: an asserted rst_n overrides a simultaneous MemWrite edge; the word stays 0.
- No X propagation after reset: unwritten words read 0.
- Address wrap-around: none. The top of the array is index DEPTH-1 (byte 4*DEPTH-4); the next word address is out of range.

Test Plan:
- Reset then read: rst_n=0 then 1, addr=0x00 and 0x08 -> read_data=0x00000000 in both cases.
- Write/readback: MemWrite=1, addr=0x08, write_data=0xDEADBEEF, one posedge; then MemWrite=0, addr=0x08 -> read_data=0xDEADBEEF.
- Neighbour isolation: after the previous case, addr=0x0C -> 0x00000000; addr=0x04 -> 0x00000000.
- Misalignment: addr=0x0B with MemWrite=0 -> 0xDEADBEEF.
- Write enable low:
  - MemWrite=0, addr=0x10, write_data=0x12345678, posedge -> addr=0x10 reads 0.
  - Same-address overwrite with 0xCAFEF00D: read_data switches from 0xDEADBEEF to 0xCAFEF00D exactly at the posedge.
- Bounds and reset priority:
  - Write 0xAAAA5555 to 4*DEPTH-4 -> it reads back.
  - Write to 4*DEPTH -> ignored; the read returns 0 and index 0 is unchanged.
  - Assert rst_n mid-cycle -> all reads 0 before the next edge.

Source files
------------

// File: rtl/memory.sv
// Word-organised data memory for the single-cycle MIPS datapath.
// Combinational read, synchronous full-word write, asynchronous clear of every word.
module memory #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [IDX_W-1:0] word_idx;
    logic             in_range;
    logic             write_en;
    logic             unused_byte_offset;

    // Byte offset only selects a lane, and lanes are not addressable here.
    assign unused_byte_offset = ^addr[1:0];
    assign word_idx           = addr[IDX_W+1:2];

    generate
        if (ADDR_W > IDX_W + 2) begin : g_range_check
            assign in_range = (addr[ADDR_W-1:IDX_W+2] == '0);
        end else begin : g_no_range_check
            assign in_range = 1'b1;
        end
    endgenerate

    assign write_en = MemWrite && in_range;

    // NOTE: the array must clear asynchronously, so it is built from resettable
    // flops rather than inferred RAM; every word gets its own reset branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en) begin
            // NOTE: non-blocking so a same-edge read sees the old word until the edge settles.
            mem_q[word_idx] <= write_data;
        end
    end

    always_comb begin
        read_data = '0;
        if (in_range) begin
            read_data = mem_q[word_idx];
        end
    end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the data memory: directed scenarios plus randomized
// traffic compared against a byte-address reference model.
module tb_memory;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;
    localparam logic [31:0] TOP_BYTE = 32'(4 * DEPTH - 4);
    localparam logic [31:0] END_BYTE = 32'(4 * DEPTH);

    logic        clk;
    logic        rst_n;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int pass_cnt;
    int total_cnt;

    logic [31:0] model [DEPTH];

    memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemWrite   (MemWrite),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (a >= END_BYTE) return 32'h0;
        return model[a / 4];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr       = a;
        write_data = d;
        MemWrite   = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        if (a < END_BYTE) model[a / 4] = d;
    endtask

    task automatic set_addr(input logic [31:0] a);
        addr = a;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] pts [2];
        pts[0] = 32'h0;
        pts[1] = 32'h8;
        rst_n = 1'b0;
        MemWrite = 1'b0;
        write_data = 32'h0;
        addr = 32'h0;
        model_clear();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_addr(pts[i]);
            total_cnt++;
            if (read_data !== 32'h0)
                $display("FAIL reset_read addr=%h got=%h exp=%h", pts[i], read_data, 32'h0);
            else pass_cnt++;
        end
    endtask

    task automatic test_write_readback();
        do_write(32'h8, 32'hDEADBEEF);
        set_addr(32'h8);
        total_cnt++;
        if (read_data !== 32'hDEADBEEF)
            $display("FAIL readback got=%h exp=%h", read_data, 32'hDEADBEEF);
        else pass_cnt++;
    endtask

    task automatic test_neighbours();
        logic [31:0] pts [2];
        pts[0] = 32'hC;
        pts[1] = 32'h4;
        for (int i = 0; i < 2; i++) begin
            set_addr(pts[i]);
            total_cnt++;
            if (read_data !== ref_read(pts[i]))
                $display("FAIL neighbour addr=%h got=%h exp=%h", pts[i], read_data, ref_read(pts[i]));
            else pass_cnt++;
        end
    endtask

    task automatic test_misalign();
        for (int off = 0; off < 4; off++) begin
            set_addr(32'h8 + 32'(off));
            total_cnt++;
            if (read_data !== 32'hDEADBEEF)
                $display("FAIL misalign addr=%h got=%h exp=%h", addr, read_data, 32'hDEADBEEF);
            else pass_cnt++;
        end
    endtask

    task automatic test_we_low();
        @(negedge clk);
        addr       = 32'h10;
        write_data = 32'h12345678;
        MemWrite   = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (read_data !== 32'h0)
            $display("FAIL we_low got=%h exp=%h", read_data, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_overwrite();
        @(negedge clk);
        addr       = 32'h8;
        write_data = 32'hCAFEF00D;
        MemWrite   = 1'b1;
        #1;
        total_cnt++;
        if (read_data !== 32'hDEADBEEF)
            $display("FAIL rdw_before got=%h exp=%h", read_data, 32'hDEADBEEF);
        else pass_cnt++;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        model[2] = 32'hCAFEF00D;
        total_cnt++;
        if (read_data !== 32'hCAFEF00D)
            $display("FAIL rdw_after got=%h exp=%h", read_data, 32'hCAFEF00D);
        else pass_cnt++;
    endtask

    task automatic test_bounds();
        do_write(TOP_BYTE, 32'hAAAA5555);
        set_addr(TOP_BYTE);
        total_cnt++;
        if (read_data !== 32'hAAAA5555)
            $display("FAIL top_word got=%h exp=%h", read_data, 32'hAAAA5555);
        else pass_cnt++;

        do_write(END_BYTE, 32'h5A5A5A5A);
        do_write(32'h8000_0008, 32'h0BADF00D);
        set_addr(END_BYTE);
        total_cnt++;
        if (read_data !== 32'h0)
            $display("FAIL oob_read got=%h exp=%h", read_data, 32'h0);
        else pass_cnt++;
        set_addr(32'h0);
        total_cnt++;
        if (read_data !== ref_read(32'h0))
            $display("FAIL oob_alias_idx0 got=%h exp=%h", read_data, ref_read(32'h0));
        else pass_cnt++;
        set_addr(32'h8);
        total_cnt++;
        if (read_data !== ref_read(32'h8))
            $display("FAIL oob_alias_idx2 got=%h exp=%h", read_data, ref_read(32'h8));
        else pass_cnt++;
    endtask

    task automatic test_reset_midcycle();
        logic [31:0] pts [3];
        pts[0] = 32'h8;
        pts[1] = TOP_BYTE;
        pts[2] = 32'h20;
        do_write(32'h20, 32'h13579BDF);
        @(negedge clk);
        addr       = 32'h20;
        write_data = 32'hFFFF0000;
        MemWrite   = 1'b1;
        #2;
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            set_addr(pts[i]);
            total_cnt++;
            if (read_data !== 32'h0)
                $display("FAIL midreset addr=%h got=%h exp=%h", pts[i], read_data, 32'h0);
            else pass_cnt++;
        end
        addr = 32'h20;
        @(posedge clk);
        #1;
        total_cnt++;
        if (read_data !== 32'h0)
            $display("FAIL reset_blocks_write got=%h exp=%h", read_data, 32'h0);
        else pass_cnt++;
        @(negedge clk);
        MemWrite = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        for (int n = 0; n < 300; n++) begin
            a = $urandom_range(0, 4 * DEPTH + 63);
            if ($urandom_range(0, 15) == 0) a[31 - $urandom_range(0, 20)] = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                do_write(a, d);
            end else begin
                @(negedge clk);
                set_addr(a);
                total_cnt++;
                if (read_data !== ref_read(a))
                    $display("FAIL random_read addr=%h got=%h exp=%h", a, read_data, ref_read(a));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 8; i++) begin
            a = 32'(4 * $urandom_range(0, DEPTH - 1));
            do_write(a, $urandom);
        end
        for (int w = 0; w < DEPTH; w++) begin
            set_addr(32'(4 * w));
            total_cnt++;
            if (read_data !== model[w])
                $display("FAIL sweep idx=%0d got=%h exp=%h", w, read_data, model[w]);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_write_readback();
        test_neighbours();
        test_misalign();
        test_we_low();
        test_overwrite();
        test_bounds();
        test_reset_midcycle();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
